// File: rtl/aibcr3aux_porseq_pkg.sv
// Shared types and widths for the AUX power-on-reset sequencer.
package aibcr3aux_porseq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DETECT   = 2'd1,
      ST_HOLD     = 2'd2,
      ST_RELEASED = 2'd3
   } porseq_state_e;

   localparam int DEB_CNT_W  = 8;
   localparam int LOSS_CNT_W = 4;

endpackage

// File: rtl/aibcr3aux_sync_deb.sv
// Multi-flop synchronizer followed by a level debouncer; the output toggles only
// after DEB_CYC consecutive synchronized samples that disagree with it.
module aibcr3aux_sync_deb
   import aibcr3aux_porseq_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYC     = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CYC - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [DEB_CNT_W-1:0]   cnt_q, cnt_d;
   logic                   lvl_q, lvl_d;
   logic                   smp;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      smp    = sync_q[SYNC_STAGES-1];
      cnt_d  = '0;
      lvl_d  = lvl_q;
      // Any agreeing sample restarts the run, so short glitches never accumulate.
      if (smp != lvl_q) begin
         if (cnt_q == DEB_LAST) begin
            lvl_d = ~lvl_q;
         end else begin
            cnt_d = cnt_q + DEB_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         lvl_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         lvl_q  <= lvl_d;
      end
   end

   assign dout = lvl_q;

endmodule

// File: rtl/aibcr3aux_por_seq.sv
// Leader-side AUX dn_por sequencer: waits for power-good and a debounced partner
// detect, holds por for HOLD_CYC cycles, then releases. AIBCR3AUX_PORSEQ_STATUS_EN adds loss_cnt.
module aibcr3aux_por_seq
   import aibcr3aux_porseq_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYC     = 16,
   parameter int HOLD_CYC    = 1024,
   parameter int CNT_W       = 11
) (
   input  logic       osc_clk,
   input  logic       rstb,
   input  logic       crdet_in,
   input  logic       pwr_ok_vccl,
   input  logic       pwr_ok_vcchssi,
   input  logic       csr_por_force,
`ifdef AIBCR3AUX_PORSEQ_STATUS_EN
   input  logic       csr_loss_clr,
   output logic [3:0] loss_cnt,
`endif
   output logic       por_to_pad,
   output logic       por_txen,
   output logic       dev_present,
   output logic       link_up,
   output logic [1:0] seq_state
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

   logic [SYNC_STAGES-1:0] vccl_sync_q, vccl_sync_d;
   logic [SYNC_STAGES-1:0] hssi_sync_q, hssi_sync_d;
   logic                   pwr_ok;
   logic                   dev_det;

   porseq_state_e          state_q, state_d;
   logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
   logic                   por_to_pad_q, por_to_pad_d;
   logic                   por_txen_q, por_txen_d;
   logic                   link_up_q, link_up_d;

   aibcr3aux_sync_deb #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYC     (DEB_CYC)
   ) u_crdet_deb (
      .clk   (osc_clk),
      .rst_n (rstb),
      .din   (crdet_in),
      .dout  (dev_det)
   );

   // Power-good is only synchronized; a drop must take the link down at once.
   always_comb begin
      vccl_sync_d = {vccl_sync_q[SYNC_STAGES-2:0], pwr_ok_vccl};
      hssi_sync_d = {hssi_sync_q[SYNC_STAGES-2:0], pwr_ok_vcchssi};
      pwr_ok      = vccl_sync_q[SYNC_STAGES-1] & hssi_sync_q[SYNC_STAGES-1];
   end

   always_comb begin
      state_d = state_q;
      if (!pwr_ok) begin
         state_d = ST_IDLE;
      end else if (!dev_det || csr_por_force) begin
         state_d = ST_DETECT;
      end else begin
         unique case (state_q)
            ST_IDLE:     state_d = ST_DETECT;
            ST_DETECT:   state_d = ST_HOLD;
            ST_HOLD:     state_d = (hold_cnt_q == HOLD_LAST) ? ST_RELEASED : ST_HOLD;
            ST_RELEASED: state_d = ST_RELEASED;
            default:     state_d = ST_IDLE;
         endcase
      end

      hold_cnt_d = hold_cnt_q;
      if (state_d == ST_HOLD) begin
         hold_cnt_d = (state_q == ST_HOLD) ? hold_cnt_q + CNT_W'(1) : '0;
      end

      // Outputs decode the next state so they move together with seq_state.
      por_to_pad_d = (state_d != ST_RELEASED);
      por_txen_d   = (state_d != ST_IDLE);
      link_up_d    = (state_d == ST_RELEASED);
   end

   always_ff @(posedge osc_clk or negedge rstb) begin
      if (!rstb) begin
         vccl_sync_q  <= '0;
         hssi_sync_q  <= '0;
         state_q      <= ST_IDLE;
         hold_cnt_q   <= '0;
         por_to_pad_q <= 1'b1;
         por_txen_q   <= 1'b0;
         link_up_q    <= 1'b0;
      end else begin
         vccl_sync_q  <= vccl_sync_d;
         hssi_sync_q  <= hssi_sync_d;
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         por_to_pad_q <= por_to_pad_d;
         por_txen_q   <= por_txen_d;
         link_up_q    <= link_up_d;
      end
   end

`ifdef AIBCR3AUX_PORSEQ_STATUS_EN
   logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
   logic                  link_lost;

   always_comb begin
      link_lost  = (state_q == ST_RELEASED) && (state_d != ST_RELEASED);
      loss_cnt_d = loss_cnt_q;
      if (csr_loss_clr) begin
         loss_cnt_d = '0;
      end else if (link_lost && (loss_cnt_q != '1)) begin
         loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
      end
   end

   always_ff @(posedge osc_clk or negedge rstb) begin
      if (!rstb) begin
         loss_cnt_q <= '0;
      end else begin
         loss_cnt_q <= loss_cnt_d;
      end
   end

   assign loss_cnt = loss_cnt_q;
`endif

   assign por_to_pad  = por_to_pad_q;
   assign por_txen    = por_txen_q;
   assign dev_present = dev_det;
   assign link_up     = link_up_q;
   assign seq_state   = state_q;

endmodule
